// File: rtl/lvds_pattern_sequencer.sv
// rtl/lvds_pattern_sequencer.sv - LVDS panel test-pattern sequencer, frame-aligned switching
// Patterns change only at frame start so pixel (0,0) of the new frame already shows the new pattern.
module lvds_pattern_sequencer #(
    parameter int H_ACTIVE           = 960,
    parameter int V_ACTIVE           = 1200,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic        i_pause,
    input  logic        i_step,
    output logic [23:0] o_color,
    output logic [23:0] o_color_even,
    output logic [2:0]  o_pattern,
    output logic        o_frame_start,
    output logic [15:0] o_frame_count
);

    localparam logic [15:0] LAST_FRAME = 16'(FRAMES_PER_PATTERN - 1);
    localparam logic [11:0] X_END      = 12'(H_ACTIVE);
    localparam logic [11:0] Y_END      = 12'(V_ACTIVE);
    localparam logic [11:0] X_LAST     = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LAST     = 12'(V_ACTIVE - 1);
    localparam logic [23:0] WHITE      = 24'hFFFFFF;

    typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t      state;
    state_t      state_next;
    logic        run_active;

    logic [11:0] prev_x;
    logic [11:0] prev_y;
    logic        step_d;
    logic        step_pending;
    logic [15:0] frame_cnt;
    logic [2:0]  pattern;

    logic        fs;
    logic        step_edge;
    logic        rollover;
    logic        advance;
    logic [2:0]  pattern_inc;
    logic [2:0]  pattern_sel;
    logic        in_range;
    logic        on_border;
    logic        checker_bit;
    logic [23:0] color_d;
    logic [23:0] color_even_d;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (i_pause)  state_next = ST_HOLD;
            ST_HOLD: if (!i_pause) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        run_active = (state == ST_RUN);
    end

    // A frame begins on (0,0) only when arriving from another coordinate.
    assign fs          = (i_x == 12'd0) && (i_y == 12'd0) && ((prev_x != 12'd0) || (prev_y != 12'd0));
    assign step_edge   = i_step & ~step_d;
    assign rollover    = fs & run_active & (frame_cnt == LAST_FRAME);
    assign advance     = fs & (step_pending | rollover);
    assign pattern_inc = (pattern == 3'd6) ? 3'd0 : pattern + 3'd1;
    assign pattern_sel = advance ? pattern_inc : pattern;

    assign in_range    = (i_x < X_END) && (i_y < Y_END);
    assign on_border   = (i_x == 12'd0) || (i_x == X_LAST) || (i_y == 12'd0) || (i_y == Y_LAST);
    assign checker_bit = i_x[3] ^ i_y[3];

    always_comb begin
        color_d      = 24'h000000;
        color_even_d = 24'h000000;
        if (in_range) begin
            case (pattern_sel)
                3'd0: begin color_d = WHITE;        color_even_d = WHITE;        end
                3'd1: begin color_d = 24'hFF0000;   color_even_d = 24'hFF0000;   end
                3'd2: begin color_d = 24'h00FF00;   color_even_d = 24'h00FF00;   end
                3'd3: begin color_d = 24'h0000FF;   color_even_d = 24'h0000FF;   end
                3'd4: begin
                    color_d      = {i_x[7:0], i_y[7:0], 8'h00};
                    color_even_d = {i_x[7:0], i_y[7:0], 8'hFF};
                end
                3'd5: begin
                    color_d      = on_border ? WHITE : 24'h000000;
                    color_even_d = on_border ? WHITE : 24'h000000;
                end
                3'd6: begin
                    color_d      = checker_bit ? WHITE : 24'h000000;
                    color_even_d = checker_bit ? 24'h000000 : WHITE;
                end
                default: begin color_d = 24'h000000; color_even_d = 24'h000000; end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            prev_x        <= 12'd0;
            prev_y        <= 12'd0;
            step_d        <= 1'b0;
            step_pending  <= 1'b0;
            frame_cnt     <= 16'd0;
            pattern       <= 3'd0;
            o_color       <= 24'h000000;
            o_color_even  <= 24'h000000;
            o_frame_start <= 1'b0;
            o_frame_count <= 16'd0;
        end else begin
            prev_x        <= i_x;
            prev_y        <= i_y;
            step_d        <= i_step;
            // A step edge on the fs cycle survives to the following frame.
            step_pending  <= step_edge | (step_pending & ~fs);
            if (advance) begin
                frame_cnt <= 16'd0;
            end else if (fs && run_active) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            pattern       <= pattern_sel;
            o_color       <= color_d;
            o_color_even  <= color_even_d;
            o_frame_start <= fs;
            if (fs) begin
                o_frame_count <= o_frame_count + 16'd1;
            end
        end
    end

    assign o_pattern = pattern;

endmodule
